// File: rtl/procsn_32.sv
// procsn_32: single-cycle 32-bit register-register execution core.
// Each cycle it decodes the R-type word on inst, reads two operands from a
// 32x32 register bank, computes the ALU result and writes it to rd on the
// next rising clock edge.
// Ports:
//   clock  - rising-edge clock for all state
//   inst   - instruction word {funct7, rs2, rs1, funct3, rd, opcode}
//   reset  - synchronous active-high clear of the register bank
//            (an undriven reset is treated as deasserted)

module procsn_32_regbank #(
    localparam int unsigned XLEN = 32,
    localparam int unsigned AW   = 5,
    localparam int unsigned NREG = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a_c,
    output logic [XLEN-1:0] rdata_b_c,
    input  logic            wr_en,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);
    // Register storage; the array name is a fixed hierarchical access point.
    logic [XLEN-1:0] regBank [0:NREG-1];

    // Asynchronous read ports: operands see the pre-write values of this cycle.
    assign rdata_a_c = regBank[raddr_a];
    assign rdata_b_c = regBank[raddr_b];

    // Synchronous clear or single write; writes to r0 are dropped so it stays 0.
    // A floating reset evaluates as unknown and falls through to the write path.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regBank[i] <= '0;
            end
        end else if (wr_en && (waddr != '0)) begin
            regBank[waddr] <= wdata;
        end
    end
endmodule

module procsn_32 (
    input  logic        clock,
    input  logic [31:0] inst,
    input  logic        reset
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 7;
    localparam int unsigned F3W  = 3;
    localparam int unsigned SHW  = 5;

    localparam logic [OPW-1:0] OP_ARITH = OPW'(7'h01);
    localparam logic [OPW-1:0] OP_SHIFT = OPW'(7'h03);
    localparam logic [OPW-1:0] OP_CMP   = OPW'(7'h07);
    localparam logic [OPW-1:0] OP_LOGIC = OPW'(7'h0F);

    // Instruction fields; funct7 carries no meaning in this core.
    logic [OPW-1:0]  opcode;
    logic [F3W-1:0]  funct3;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            unused_funct7;

    assign opcode        = inst[6:0];
    assign rd            = inst[11:7];
    assign funct3        = inst[14:12];
    assign rs1           = inst[19:15];
    assign rs2           = inst[24:20];
    assign unused_funct7 = ^inst[31:25];

    logic [XLEN-1:0] a_c;
    logic [XLEN-1:0] b_c;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] result_c;
    logic            wr_en_c;

    assign shamt_c = b_c[SHW-1:0];

    // Decode + ALU. Unlisted opcode/funct3 pairs (including X/Z values, which
    // match no case item) leave wr_en_c low so nothing is written.
    always_comb begin
        result_c = '0;
        wr_en_c  = 1'b0;
        case (opcode)
            OP_ARITH: begin
                case (funct3)
                    3'd0: begin result_c = a_c + b_c; wr_en_c = 1'b1; end
                    3'd1: begin result_c = a_c - b_c; wr_en_c = 1'b1; end
                    default: ;
                endcase
            end
            OP_SHIFT: begin
                case (funct3)
                    3'd0: begin result_c = a_c << shamt_c; wr_en_c = 1'b1; end
                    3'd1: begin result_c = a_c >> shamt_c; wr_en_c = 1'b1; end
                    3'd2: begin
                        result_c = XLEN'($signed(a_c) >>> shamt_c);
                        wr_en_c  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_CMP: begin
                case (funct3)
                    3'd0: begin
                        result_c = XLEN'($signed(a_c) < $signed(b_c));
                        wr_en_c  = 1'b1;
                    end
                    3'd1: begin
                        result_c = XLEN'(a_c < b_c);
                        wr_en_c  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LOGIC: begin
                case (funct3)
                    3'd0: begin result_c = a_c ^ b_c; wr_en_c = 1'b1; end
                    3'd1: begin result_c = a_c | b_c; wr_en_c = 1'b1; end
                    3'd2: begin result_c = a_c & b_c; wr_en_c = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    procsn_32_regbank regB (
        .clock     (clock),
        .reset     (reset),
        .raddr_a   (rs1),
        .raddr_b   (rs2),
        .rdata_a_c (a_c),
        .rdata_b_c (b_c),
        .wr_en     (wr_en_c),
        .waddr     (rd),
        .wdata     (result_c)
    );
endmodule

// File: tb/tb_procsn_32.sv
// Self-checking bench for procsn_32: preloads registers through the bank
// hierarchy, runs a table of instructions, and compares the whole bank
// against a bench-side expected register image after every edge.
module tb_procsn_32;
    logic        clock;
    logic [31:0] inst;
    logic        reset;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [0:31];

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          wr;
    } vec_t;

    vec_t vecs[$];

    procsn_32 DUT (
        .clock (clock),
        .inst  (inst),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, rd, op};
    endfunction

    // Compare every register against the expected image.
    task automatic check_bank(input string name);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (DUT.regB.regBank[i] !== model[i]) begin
                failures++;
                $display("FAIL %s r%0d got=%h exp=%h", name, i, DUT.regB.regBank[i], model[i]);
            end
        end
    endtask

    // Called at a negedge: drive one instruction, let one rising edge pass, check.
    task automatic run_vec(input vec_t v);
        inst = v.inst;
        @(negedge clock);
        if (v.wr && v.rd != 5'd0) model[v.rd] = v.exp;
        check_bank(v.name);
    endtask

    initial begin
        logic [6:0] xop;
        vec_t       hv;
        xop   = 7'b1x00000;
        inst  = 32'h0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_bank("reset_state");

        // Preload through the hierarchy; inst=0 is an illegal opcode, so no writes race.
        model[1] = 32'h0000000F; model[2] = 32'h0000000C; model[3] = 32'hFF0000FF;
        model[4] = 32'h00000004; model[5] = 32'h70000000; model[6] = 32'hF0000000;
        for (int i = 1; i <= 6; i++) DUT.regB.regBank[i] = model[i];
        @(negedge clock);
        check_bank("preload");

        vecs.push_back(vec_t'{"add",    enc(7'h01, 3'd0, 5'd10, 5'd1, 5'd2), 5'd10, 32'h0000001B, 1'b1});
        vecs.push_back(vec_t'{"sub",    enc(7'h01, 3'd1, 5'd11, 5'd1, 5'd2), 5'd11, 32'h00000003, 1'b1});
        vecs.push_back(vec_t'{"sll",    enc(7'h03, 3'd0, 5'd12, 5'd3, 5'd4), 5'd12, 32'hF0000FF0, 1'b1});
        vecs.push_back(vec_t'{"srl",    enc(7'h03, 3'd1, 5'd13, 5'd3, 5'd4), 5'd13, 32'h0FF0000F, 1'b1});
        vecs.push_back(vec_t'{"sra",    enc(7'h03, 3'd2, 5'd14, 5'd3, 5'd4), 5'd14, 32'hFFF0000F, 1'b1});
        vecs.push_back(vec_t'{"slt",    enc(7'h07, 3'd0, 5'd15, 5'd5, 5'd6), 5'd15, 32'h00000000, 1'b1});
        vecs.push_back(vec_t'{"sltu",   enc(7'h07, 3'd1, 5'd16, 5'd5, 5'd6), 5'd16, 32'h00000001, 1'b1});
        vecs.push_back(vec_t'{"xor",    enc(7'h0F, 3'd0, 5'd17, 5'd1, 5'd2), 5'd17, 32'h00000003, 1'b1});
        vecs.push_back(vec_t'{"or",     enc(7'h0F, 3'd1, 5'd18, 5'd1, 5'd2), 5'd18, 32'h0000000F, 1'b1});
        vecs.push_back(vec_t'{"and",    enc(7'h0F, 3'd2, 5'd19, 5'd1, 5'd2), 5'd19, 32'h0000000C, 1'b1});
        vecs.push_back(vec_t'{"rd0",    enc(7'h01, 3'd0, 5'd0,  5'd1, 5'd2), 5'd0,  32'h0,        1'b0});
        vecs.push_back(vec_t'{"op7f",   enc(7'h7F, 3'd0, 5'd20, 5'd1, 5'd2), 5'd20, 32'h0,        1'b0});
        vecs.push_back(vec_t'{"arf3",   enc(7'h01, 3'd3, 5'd20, 5'd1, 5'd2), 5'd20, 32'h0,        1'b0});
        vecs.push_back(vec_t'{"shf3",   enc(7'h03, 3'd3, 5'd20, 5'd1, 5'd2), 5'd20, 32'h0,        1'b0});
        vecs.push_back(vec_t'{"cmpf3",  enc(7'h07, 3'd2, 5'd20, 5'd1, 5'd2), 5'd20, 32'h0,        1'b0});
        vecs.push_back(vec_t'{"lgf3",   enc(7'h0F, 3'd3, 5'd20, 5'd1, 5'd2), 5'd20, 32'h0,        1'b0});
        vecs.push_back(vec_t'{"xop",    enc(xop,   3'd0, 5'd20, 5'd1, 5'd2), 5'd20, 32'h0,        1'b0});
        vecs.push_back(vec_t'{"sub_neg",enc(7'h01, 3'd1, 5'd7,  5'd2, 5'd1), 5'd7,  32'hFFFFFFFD, 1'b1});
        vecs.push_back(vec_t'{"sll0",   enc(7'h03, 3'd0, 5'd24, 5'd3, 5'd6), 5'd24, 32'hFF0000FF, 1'b1});
        vecs.push_back(vec_t'{"sra31",  enc(7'h03, 3'd2, 5'd25, 5'd6, 5'd3), 5'd25, 32'hFFFFFFFF, 1'b1});
        vecs.push_back(vec_t'{"srl31",  enc(7'h03, 3'd1, 5'd28, 5'd6, 5'd3), 5'd28, 32'h00000001, 1'b1});
        vecs.push_back(vec_t'{"slt_neg",enc(7'h07, 3'd0, 5'd26, 5'd6, 5'd5), 5'd26, 32'h00000001, 1'b1});
        vecs.push_back(vec_t'{"sltu_hi",enc(7'h07, 3'd1, 5'd29, 5'd6, 5'd5), 5'd29, 32'h00000000, 1'b1});
        vecs.push_back(vec_t'{"add_ovf",enc(7'h01, 3'd0, 5'd27, 5'd6, 5'd6), 5'd27, 32'hE0000000, 1'b1});

        foreach (vecs[k]) run_vec(vecs[k]);

        // rd also a source: operands are the pre-write values, then back-to-back reuse.
        hv = vec_t'{"rd_eq_rs", enc(7'h01, 3'd0, 5'd1, 5'd1, 5'd1), 5'd1, 32'h0000001E, 1'b1};
        run_vec(hv);
        hv = vec_t'{"b2b_dep",  enc(7'h01, 3'd0, 5'd22, 5'd1, 5'd2), 5'd22, 32'h0000002A, 1'b1};
        run_vec(hv);
        hv = vec_t'{"b2b_dep2", enc(7'h01, 3'd1, 5'd23, 5'd22, 5'd1), 5'd23, 32'h0000000C, 1'b1};
        run_vec(hv);

        // Reset for one edge with a valid instruction present: bank clears, no write.
        inst  = enc(7'h01, 3'd0, 5'd21, 5'd1, 5'd2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        check_bank("mid_reset");

        hv = vec_t'{"add_post_rst", enc(7'h01, 3'd0, 5'd10, 5'd1, 5'd2), 5'd10, 32'h0, 1'b1};
        run_vec(hv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/procsn_32.md
# procsn_32

Single-cycle 32-bit register-register processor datapath (`procsn32`): decodes one 32-bit R-type instruction per clock, reads two operands from a 32×32 register bank, computes an ALU result and writes it back to the destination register. No PC, fetch, memory or immediates; instructions are driven directly on `inst`. Sits under the top level as the execution core; benches preload and inspect registers hierarchically.

## Interface
- No parameters (data width 32, 32 registers, fixed).
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset.
- `inst`  in  32  instruction word, sampled every cycle.
- Port order for positional instantiation: `clock`, `inst`, `reset`. An unconnected `reset` (z) must behave as deasserted.
- Register bank: submodule instance `regB` holding array `regBank[0:31]` of 32-bit regs. Benches read and write it by hierarchical path (`DUT.regB.regBank[n]`), so these names and this array form are mandatory.

## Operation
- Fields: funct7 = inst[31:25] (ignored), rs2 = inst[24:20], rs1 = inst[19:15], funct3 = inst[14:12], rd = inst[11:7], opcode = inst[6:0].
- A = regBank[rs1], B = regBank[rs2]. Reads are combinational.
- opcode 0x01, arithmetic: funct3 0 ADD, A+B; funct3 1 SUB, A−B. Both mod 2^32, no flags.
- opcode 0x03, shifts, shift amount = B[4:0]: funct3 0 SLL; funct3 1 SRL (zero fill); funct3 2 SRA (sign fill from A[31]).
- opcode 0x07, compare, result 32'h1 or 32'h0: funct3 0 SLT (signed A<B); funct3 1 SLTU (unsigned A<B).
- opcode 0x0F, logic: funct3 0 XOR; funct3 1 OR; funct3 2 AND.
- Any other opcode/funct3 combination, or an inst containing X/Z in opcode or funct3: no register write.
- rd = 0: write suppressed; regBank[0] always reads as stored value, and reset forces it to 0.
- rs1 or rs2 may equal rd. Operands are the pre-write values.

## Timing
- Decode and ALU are combinational from `inst` and the register bank.
- Writeback: regBank[rd] ← result on the rising `clock` edge at the end of the cycle in which `inst` is stable. Latency is one edge; one instruction per cycle.
- `inst` changing coincident with a rising edge: the value from before the edge is executed at that edge. The new value executes at the following edge.
- Reset (synchronous): at a rising edge with `reset`=1, all 32 registers clear to 0 and no instruction writes that cycle. Reset mid-stream discards the instruction present in that cycle.
- No stalls, no hazards (single-cycle, write-then-read across edges).

## Test plan
Preload r1=0x0000000F, r2=0x0000000C, r3=0xFF0000FF, r4=0x00000004, r5=0x70000000, r6=0xF0000000. Apply one instruction per 20 ns cycle and check each destination one edge later.
- ADD r10=r1+r2 → 0x0000001B. SUB r11=r1−r2 → 0x00000003.
- SLL r12=r3<<r4 → 0xF0000FF0. SRL r13 → 0x0FF0000F. SRA r14 → 0xFFF0000F.
- SLT r15=(r5<r6 signed) → 0x00000000. SLTU r16 → 0x00000001.
- XOR r17 → 0x00000003. OR r18 → 0x0000000F. AND r19 → 0x0000000C.
- rd=0 ADD (r1,r2) → r0 unchanged. opcode 0x7F or funct3=3 with opcode 0x01 → no register changes. SUB r7=r2−r1 → 0xFFFFFFFD.
- Assert `reset` for one edge after the loads → all regBank entries 0. A later ADD r10=r1+r2 → 0.
